// File: rtl/instr_fetch.sv
// Instruction fetch stage: program counter, single-outstanding-read issue to a
// synchronous instruction memory, and a two-entry {instr, pc} buffer presented
// to decode through a valid/ready handshake. A taken branch (redirect) flushes
// the buffer, drops any returning read and restarts fetch at the target.
module instr_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [2:0]          opcode
);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [1:0]         count;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  // Entry 0 is always the head; entry 1 only holds data when count == 2.
  logic [INSTR_W-1:0] buf_instr [2];
  logic [ADDR_W-1:0]  buf_pc    [2];

  logic               pop;
  logic [2:0]         occupancy;
  logic               wr_sel;

  // Handshake, issue decision and output presentation.
  always_comb begin
    instr_valid = !reset && (count != 2'd0);
    pop         = instr_valid && instr_ready;
    // Slots committed after this edge: buffered + in flight - leaving now.
    occupancy   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    imem_req    = !reset && !redirect && (occupancy < 3'd2);
    imem_addr   = fetch_pc;
    instr       = instr_valid ? buf_instr[0] : '0;
    instr_pc    = instr_valid ? buf_pc[0]    : '0;
    opcode      = instr[INSTR_W-1 -: 3];
    // Tail slot for the returning word, accounting for a same-cycle pop.
    wr_sel      = (count == 2'd2) || ((count == 2'd1) && !pop);
  end

  // PC, in-flight tracking, buffer occupancy and buffer contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      count       <= 2'd0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      // A pop this cycle still completes; everything else is discarded.
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      count    <= 2'd0;
      inflight <= 1'b0;
    end else begin
      if (imem_req) begin
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + ADDR_W'(4);
      end else begin
        inflight <= 1'b0;
      end
      count <= count + {1'b0, inflight} - {1'b0, pop};
      if (pop) begin
        buf_instr[0] <= buf_instr[1];
        buf_pc[0]    <= buf_pc[1];
      end
      // Placed after the shift so a push into slot 0 wins over it.
      if (inflight) begin
        buf_instr[wr_sel] <= imem_rdata;
        buf_pc[wr_sel]    <= inflight_pc;
      end
    end
  end

endmodule
